// File: rtl/riscv_pkg.sv
// Shared core types: memory operation/size encodings and byte-enable constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit: byte enables,
// lane-replicated store data, load extraction with sign/zero extension.
// Offset bits finer than the access size are ignored (natural alignment).
module lsu_align
  import riscv_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  // Lane selection and extension per access size.
  always_comb begin
    misaligned_o = is_misaligned(size_i, off_i);
    be_o         = BE_W;
    wdata_o      = sdata_i;
    ldata_o      = rdata_i;
    shifted      = rdata_i;
    case (size_i)
      SZ_B: begin
        shifted = rdata_i >> {off_i, 3'b000};
        be_o    = BE_B << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        shifted = rdata_i >> {off_i[1], 4'b0000};
        be_o    = BE_H << {off_i[1], 1'b0};
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one data-memory transaction per load/store over a
// req/gnt/rvalid bus, result delivered to writeback via valid/ready.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and
// raise o_misaligned / o_bad_addr.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int wd_regs_p = 32,
  parameter int n_regs_p  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [wd_regs_p-1:0]        i_result,
  input  logic [wd_regs_p-1:0]        i_store_data,
  input  mem_op_t                     i_mem_op,
  input  mem_size_t                   i_mem_size,
  input  logic                        i_mem_unsigned,
  input  logic [$clog2(n_regs_p)-1:0] i_rdest,
  input  logic                        i_wb_en,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [wd_regs_p-1:0]        o_wb_data,
  output logic [$clog2(n_regs_p)-1:0] o_rdest,
  output logic                        o_wb_en,
  output logic                        o_dmem_req,
  input  logic                        i_dmem_gnt,
  output logic                        o_dmem_we,
  output logic [wd_regs_p-1:0]        o_dmem_addr,
  output logic [3:0]                  o_dmem_be,
  output logic [wd_regs_p-1:0]        o_dmem_wdata,
  input  logic                        i_dmem_rvalid,
  input  logic [wd_regs_p-1:0]        i_dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                        o_misaligned,
  output logic [wd_regs_p-1:0]        o_bad_addr
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [wd_regs_p-1:0]        addr_q, wdata_q, wb_data_q;
  logic [3:0]                  be_q;
  logic                        we_q, wb_en_q, uns_q;
  mem_size_t                   size_q;
  logic [1:0]                  off_q;
  logic [$clog2(n_regs_p)-1:0] rdest_q;

  // The aligner sees the incoming op while idle (to build be/wdata) and the
  // latched op afterwards (to extract load data).
  mem_size_t   al_size;
  logic [1:0]  al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        al_mis;
  logic        trap_mis;

  assign al_size = (state_q == IDLE) ? i_mem_size     : size_q;
  assign al_off  = (state_q == IDLE) ? i_result[1:0]  : off_q;
  assign al_uns  = (state_q == IDLE) ? i_mem_unsigned : uns_q;

  lsu_align u_align (
    .size_i       (al_size),
    .off_i        (al_off),
    .unsigned_i   (al_uns),
    .sdata_i      (i_store_data),
    .rdata_i      (i_dmem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .ldata_o      (al_ldata),
    .misaligned_o (al_mis)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_mis = al_mis;
`else
  logic unused_mis;
  assign unused_mis = al_mis;
  assign trap_mis   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and accept strobe.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        accept = 1'b1;
        if (i_mem_op == MEM_NONE || trap_mis) state_d = RESP;
        else                                  state_d = REQ;
      end
      REQ:  if (i_dmem_gnt)    state_d = WAIT;
      WAIT: if (i_dmem_rvalid) state_d = RESP;
      RESP: if (i_ready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation latch, bus fields and writeback result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_B;
      off_q     <= '0;
      rdest_q   <= '0;
    end else if (accept) begin
      rdest_q <= i_rdest;
      if (i_mem_op == MEM_NONE) begin
        wb_data_q <= i_result;
        wb_en_q   <= i_wb_en;
      end else begin
        addr_q  <= {i_result[wd_regs_p-1:2], 2'b00};
        we_q    <= (i_mem_op == MEM_STORE);
        be_q    <= al_be;
        wdata_q <= al_wdata;
        size_q  <= i_mem_size;
        off_q   <= i_result[1:0];
        uns_q   <= i_mem_unsigned;
        wb_en_q <= i_wb_en & ~trap_mis;
      end
    end else if (state_q == WAIT && i_dmem_rvalid) begin
      if (we_q) wb_en_q   <= 1'b0;
      else      wb_data_q <= al_ldata;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic                 mis_q;
  logic [wd_regs_p-1:0] bad_addr_q;

  // One-cycle misalignment pulse; faulting address held until next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q      <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      mis_q <= accept && (i_mem_op != MEM_NONE) && al_mis;
      if (accept) bad_addr_q <= i_result;
    end
  end

  assign o_misaligned = mis_q;
  assign o_bad_addr   = bad_addr_q;
`endif

  assign o_ready      = rst_n && (state_q == IDLE);
  assign o_valid      = (state_q == RESP);
  assign o_dmem_req   = (state_q == REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_data    = wb_data_q;
  assign o_rdest      = rdest_q;
  assign o_wb_en      = wb_en_q;

endmodule
